mmio_timer: RTL and testbench
=============================

// Module: mmio_timer
// PURPOSE
//  Memory-mapped timer peripheral that answers the CPU's MEM-stage load/store bus
//  (MemRead/MemWrite/address/write_data -> read_data).
//  - Reloadable 32-bit up-counter with interrupt generation.
//  - Sits beside the data memory. The CPU muxes read_data in when hit=1.
//  - Reads are same-cycle combinational, matching the data memory.
//  - Writes commit on the rising clk edge.
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  byte base address of the 16-byte register window
//  PRESCALE   1              clk cycles per counter tick (>=1; 1 = tick every cycle)
// PORTS
//  clk         input   1   system clock
//  reset       input   1   synchronous, active-high reset
//  MemRead     input   1   load strobe from the CPU MEM stage
//  MemWrite    input   1   store strobe from the CPU MEM stage
//  address     input   32  byte address from the CPU (ex_mem ALU result)
//  write_data  input   32  store data (rt)
//  read_data   output  32  load data, combinational
//  hit         output  1   address lies in [BASE_ADDR, BASE_ADDR+15]
//  irq         output  1   interrupt request (level)
// BEHAVIOUR
//  - Clocking: single clk. Synchronous, active-high reset.
//  - Register map (offset = address[3:2]; address[1:0] ignored; word access only):
//      0x0 TH    reload value, R/W
//      0x4 TL    counter, R/W
//      0x8 TCON  R/W. [0] EN, [1] IE, [2] IF (sticky status). [31:3] read 0.
//      0xC       see CONFIGURATION
//  - Reset: TH=0, TL=0, TCON=0, prescale count=0, irq=0.
//    read_data and hit are combinational only.
//  - hit: (address & ~32'hF) == BASE_ADDR. hit does not depend on MemRead/MemWrite.
//  - read_data: register selected by offset when MemRead & hit, else 32'h0.
//  - Writes: take effect at the clk edge when MemWrite & hit. Writes outside the window are ignored.
//  - Ticking:
//      - With EN=1, the prescale counter runs 0..PRESCALE-1.
//      - A tick fires on the cycle the counter equals PRESCALE-1; the counter then wraps to 0.
//      - EN=0 holds the prescale counter at 0 and freezes TL.
//  - On a tick:
//      - TL != 32'hFFFF_FFFF: TL <= TL+1.
//      - TL == 32'hFFFF_FFFF: TL <= TH (reload). If IE=1, IF <= 1.
//  - irq = IF & IE, registered. It asserts the cycle after the overflow tick.
//  - TCON write:
//      - EN and IE take write_data[1:0].
//      - IF is write-1-to-clear: write_data[2]=1 clears it; 0 leaves it unchanged.
//  - Simultaneous events:
//      - CPU write to TL on a tick cycle: the write wins; the tick is discarded.
//      - CPU clears IF on an overflow cycle: the set wins; IF stays 1.
//      - Write to TH on a reload cycle: TL takes the old TH; TH takes the new value.
//  - Reset asserted mid-count: all state returns to reset values on that edge; no irq is produced.
//  - Loads have zero added latency.
//  - The block never stalls the pipeline.
// CONFIGURATION
//  TIMER_SYSTICK_EN defined:
//   - Offset 0xC is SYSTICK, a read-only free-running 32-bit count of clk cycles since reset.
//   - SYSTICK resets to 0, wraps modulo 2^32 and ignores writes.
//  TIMER_SYSTICK_EN undefined:
//   - Offset 0xC reads 32'h0 and writes are ignored.
//   - No SYSTICK flops exist.
// TESTING
//  1. Reset, then load all offsets -> read_data=0 for all, irq=0.
//     Load 0x3FFF_FFFC -> hit=0, read_data=0.
//  2. PRESCALE=1:
//     - Set TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3.
//     - TL reads FFFF_FFFF after 1 cycle and FFFF_FFF0 after 2 cycles.
//     - IF=1 and irq=1 one cycle after the reload.
//  3. Write TCON=0x4|0x3 with IF=1 -> IF=0 and irq drops next cycle.
//     Repeat on an overflow cycle -> IF stays 1.
//  4. PRESCALE=4, TL=0, EN=1 -> TL=1 after 4 cycles, TL=2 after 8.
//     Clear EN at TL=2 -> TL holds 2 for 10 cycles.
//  5. Write TL=0x55 on a tick cycle -> TL=0x55, not 0x56.
//     Assert reset mid-count -> TL=0, TCON=0, irq=0.
//  6. TIMER_SYSTICK_EN defined: load 0xC at cycles 10 and 20 after reset -> the values differ by exactly 10.
//     Macro undefined -> load 0xC returns 0.

Source files
------------

// File: rtl/mmio_timer_if.sv
// CPU MEM-stage load/store bus between the pipeline (master) and the timer peripheral (slave).
interface mmio_timer_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;
    logic        irq;

    modport master (
        output MemRead, MemWrite, address, write_data,
        input  read_data, hit, irq
    );

    modport slave (
        input  MemRead, MemWrite, address, write_data,
        output read_data, hit, irq
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped reloadable 32-bit up-counter with prescaler and level interrupt.
// Optional macro TIMER_SYSTICK_EN adds a read-only free-running cycle counter at offset 0xC.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    mmio_timer_if.slave bus
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [31:0]   r_th;
    logic [31:0]   r_tl;
    logic          r_en;
    logic          r_ie;
    logic          r_if;
    logic          r_irq;
    logic [PW-1:0] r_pre;

    logic          w_hit;
    logic          w_wr;
    logic [1:0]    w_off;
    logic          w_tick;
    logic          w_ovf;
    logic [31:0]   w_th_next;
    logic [31:0]   w_tl_next;
    logic          w_en_next;
    logic          w_ie_next;
    logic          w_if_next;
    logic [31:0]   w_systick;
    logic [31:0]   w_reg_sel;

    assign w_hit  = (bus.address & ~32'hF) == BASE_ADDR;
    assign w_off  = bus.address[3:2];
    assign w_wr   = bus.MemWrite & w_hit;
    assign w_tick = r_en & (r_pre == PRE_MAX);
    assign w_ovf  = w_tick & (r_tl == 32'hFFFF_FFFF);

    // CPU writes override the tick on TL; an overflow set of IF beats a W1C clear.
    always_comb begin
        w_th_next = r_th;
        w_tl_next = r_tl;
        w_en_next = r_en;
        w_ie_next = r_ie;
        w_if_next = r_if;
        if (w_tick) begin
            w_tl_next = w_ovf ? r_th : r_tl + 32'd1;
        end
        if (w_wr) begin
            case (w_off)
                2'd0: w_th_next = bus.write_data;
                2'd1: w_tl_next = bus.write_data;
                2'd2: begin
                    w_en_next = bus.write_data[0];
                    w_ie_next = bus.write_data[1];
                    if (bus.write_data[2]) begin
                        w_if_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (w_ovf & r_ie) begin
            w_if_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_th  <= 32'h0;
            r_tl  <= 32'h0;
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_if  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_th  <= w_th_next;
            r_tl  <= w_tl_next;
            r_en  <= w_en_next;
            r_ie  <= w_ie_next;
            r_if  <= w_if_next;
            r_irq <= w_if_next & w_ie_next;
        end
    end

    // Prescaler parks at 0 while disabled so re-enabling always gives a full period.
    always_ff @(posedge clk) begin
        if (reset || !r_en || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

`ifdef TIMER_SYSTICK_EN
    logic [31:0] r_systick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_systick <= 32'h0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    assign w_systick = r_systick;
`else
    assign w_systick = 32'h0;
`endif

    always_comb begin
        w_reg_sel = 32'h0;
        case (w_off)
            2'd0: w_reg_sel = r_th;
            2'd1: w_reg_sel = r_tl;
            2'd2: w_reg_sel = {29'h0, r_if, r_ie, r_en};
            default: w_reg_sel = w_systick;
        endcase
    end

    assign bus.read_data = (bus.MemRead & w_hit) ? w_reg_sel : 32'h0;
    assign bus.hit       = w_hit;
    assign bus.irq       = r_irq;
endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) against a cycle-level behavioural model,
// plus directed loads with hand-computed expectations.
`timescale 1ns/1ps
module tb_mmio_timer;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'd4;
    localparam logic [31:0] A_TCON = BASE + 32'd8;
    localparam logic [31:0] A_SYS  = BASE + 32'd12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chkEn = 1'b0;
    int   nAssert = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    logic        sRd   [2];
    logic        sWr   [2];
    logic [31:0] sAddr [2];
    logic [31:0] sData [2];

    mmio_timer_if bus0 ();
    mmio_timer_if bus1 ();

    assign bus0.MemRead    = sRd[0];
    assign bus0.MemWrite   = sWr[0];
    assign bus0.address    = sAddr[0];
    assign bus0.write_data = sData[0];
    assign bus1.MemRead    = sRd[1];
    assign bus1.MemWrite   = sWr[1];
    assign bus1.address    = sAddr[1];
    assign bus1.write_data = sData[1];

    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    // Behavioural model state
    logic [31:0] mTH [2];
    logic [31:0] mTL [2];
    logic        mEN [2];
    logic        mIE [2];
    logic        mIF [2];
    int          mPre [2];
    logic [31:0] mSys;

    function automatic int prescaleOf(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic bit inWindow(logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    function automatic logic [31:0] expRead(int i);
        if (!(sRd[i] && inWindow(sAddr[i]))) return 32'h0;
        case ((sAddr[i] - BASE) / 4)
            0: return mTH[i];
            1: return mTL[i];
            2: return {29'h0, mIF[i], mIE[i], mEN[i]};
            default: begin
`ifdef TIMER_SYSTICK_EN
                return mSys;
`else
                return 32'h0;
`endif
            end
        endcase
    endfunction

    function automatic logic [31:0] actRd(int i);
        return (i == 0) ? bus0.read_data : bus1.read_data;
    endfunction

    function automatic logic actHit(int i);
        return (i == 0) ? bus0.hit : bus1.hit;
    endfunction

    function automatic logic actIrq(int i);
        return (i == 0) ? bus0.irq : bus1.irq;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        bit          tick;
        bit          setIf;
        logic [31:0] nTL;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mTH[i] = 0; mTL[i] = 0; mEN[i] = 0; mIE[i] = 0; mIF[i] = 0; mPre[i] = 0;
            end
            mSys = 0;
            return;
        end
        mSys = mSys + 1;
        for (int i = 0; i < 2; i++) begin
            tick  = mEN[i] && (mPre[i] == prescaleOf(i) - 1);
            setIf = 0;
            nTL   = mTL[i];
            mPre[i] = mEN[i] ? (mPre[i] + 1) % prescaleOf(i) : 0;
            if (tick) begin
                if (mTL[i] == 32'hFFFF_FFFF) begin
                    nTL = mTH[i];
                    setIf = mIE[i];
                end else begin
                    nTL = mTL[i] + 1;
                end
            end
            if (sWr[i] && inWindow(sAddr[i])) begin
                case ((sAddr[i] - BASE) / 4)
                    0: mTH[i] = sData[i];
                    1: nTL = sData[i];
                    2: begin
                        mEN[i] = sData[i][0];
                        mIE[i] = sData[i][1];
                        if (sData[i][2]) mIF[i] = 0;
                    end
                    default: ;
                endcase
            end
            if (setIf) mIF[i] = 1;
            mTL[i] = nTL;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (chkEn) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("hit%0d", i), {31'h0, actHit(i)}, {31'h0, inWindow(sAddr[i])});
                checkOutput($sformatf("rdata%0d", i), actRd(i), expRead(i));
                checkOutput($sformatf("irq%0d", i), {31'h0, actIrq(i)}, {31'h0, mIF[i] & mIE[i]});
            end
        end
    end

    task automatic drive(int inst, logic rd, logic wr, logic [31:0] addr, logic [31:0] data);
        for (int j = 0; j < 2; j++) begin
            sRd[j] = 1'b0; sWr[j] = 1'b0; sAddr[j] = 32'h0; sData[j] = 32'h0;
        end
        sRd[inst] = rd; sWr[inst] = wr; sAddr[inst] = addr; sData[inst] = data;
    endtask

    task automatic applyStimulus(int inst, logic rd, logic wr, logic [31:0] addr, logic [31:0] data);
        drive(inst, rd, wr, addr, data);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic readExpect(int inst, logic [31:0] addr, logic [31:0] exp, string name,
                              bit chkIrq = 0, logic expIrq = 1'b0);
        drive(inst, 1'b1, 1'b0, addr, 32'h0);
        @(negedge clk);
        checkOutput(name, actRd(inst), exp);
        if (chkIrq) checkOutput({name, "_irq"}, {31'h0, actIrq(inst)}, {31'h0, expIrq});
        @(posedge clk);
        #1;
    endtask

    task automatic hitExpect(int inst, logic [31:0] addr, logic expHit, string name);
        drive(inst, 1'b0, 1'b0, addr, 32'h0);
        @(negedge clk);
        checkOutput(name, {31'h0, actHit(inst)}, {31'h0, expHit});
        checkOutput({name, "_rd"}, actRd(inst), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chkEn = 1'b1;

        $display("[TB] reset values and address decode");
        readExpect(0, A_SYS,  32'h0, "rst_sys", 1, 1'b0);
        readExpect(0, A_TH,   32'h0, "rst_th",  1, 1'b0);
        readExpect(0, A_TL,   32'h0, "rst_tl");
        readExpect(0, A_TCON, 32'h0, "rst_tcon");
        readExpect(1, A_TCON, 32'h0, "rst_tcon1", 1, 1'b0);
        readExpect(0, 32'h3FFF_FFFC, 32'h0, "outside_rd");
        hitExpect(0, 32'h3FFF_FFFC, 1'b0, "hit_below");
        hitExpect(0, 32'h4000_000F, 1'b1, "hit_top");
        hitExpect(0, 32'h4000_0010, 1'b0, "hit_above");

        $display("[TB] overflow and reload, prescale 1");
        applyStimulus(0, 1'b0, 1'b1, A_TH,   32'hFFFF_FFF0);
        applyStimulus(0, 1'b0, 1'b1, A_TL,   32'hFFFF_FFFE);
        applyStimulus(0, 1'b0, 1'b1, A_TCON, 32'h0000_0003);
        readExpect(0, A_TL,   32'hFFFF_FFFE, "tl_c0");
        readExpect(0, A_TL,   32'hFFFF_FFFF, "tl_c1", 1, 1'b0);
        readExpect(0, A_TL,   32'hFFFF_FFF0, "tl_reload", 1, 1'b1);
        readExpect(0, A_TCON, 32'h0000_0007, "tcon_if", 1, 1'b1);

        $display("[TB] IF write-1-to-clear and set priority");
        applyStimulus(0, 1'b0, 1'b1, A_TCON, 32'h0000_0007);
        readExpect(0, A_TCON, 32'h0000_0003, "if_clear", 1, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, A_TL,   32'hFFFF_FFFF);
        applyStimulus(0, 1'b0, 1'b1, A_TCON, 32'h0000_0007);
        readExpect(0, A_TCON, 32'h0000_0007, "if_set_wins", 1, 1'b1);
        readExpect(0, A_TL,   32'hFFFF_FFF1, "tl_after_ovf");

        $display("[TB] TH write on reload cycle");
        applyStimulus(0, 1'b0, 1'b1, A_TL, 32'hFFFF_FFFF);
        applyStimulus(0, 1'b0, 1'b1, A_TH, 32'h0000_1234);
        readExpect(0, A_TL, 32'hFFFF_FFF0, "reload_old_th");
        readExpect(0, A_TH, 32'h0000_1234, "th_new");
        applyStimulus(0, 1'b0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        readExpect(0, BASE + 32'd3, 32'h0000_1234, "th_ignore_outside");

        $display("[TB] TL write beats tick");
        applyStimulus(0, 1'b0, 1'b1, A_TL, 32'h0000_0055);
        readExpect(0, A_TL, 32'h0000_0055, "tl_write_wins");

        $display("[TB] prescale 4 and enable freeze");
        applyStimulus(1, 1'b0, 1'b1, A_TL,   32'h0);
        applyStimulus(1, 1'b0, 1'b1, A_TCON, 32'h1);
        idle(4);
        readExpect(1, A_TL, 32'h1, "ps4_tl1");
        idle(3);
        readExpect(1, A_TL, 32'h2, "ps4_tl2");
        applyStimulus(1, 1'b0, 1'b1, A_TCON, 32'h0);
        for (int k = 0; k < 10; k++) readExpect(1, A_TL, 32'h2, $sformatf("ps4_hold%0d", k));

        $display("[TB] reset on an overflow cycle");
        applyStimulus(0, 1'b0, 1'b1, A_TCON, 32'h0000_0007);
        applyStimulus(0, 1'b0, 1'b1, A_TL,   32'hFFFF_FFFF);
        pulseReset();
        readExpect(0, A_TL,   32'h0, "rst_mid_tl", 1, 1'b0);
        readExpect(0, A_TCON, 32'h0, "rst_mid_tcon", 1, 1'b0);
        readExpect(1, A_TL,   32'h0, "rst_mid_tl1");

`ifdef TIMER_SYSTICK_EN
        $display("[TB] systick");
        pulseReset();
        idle(10);
        drive(0, 1'b1, 1'b0, A_SYS, 32'h0);
        @(negedge clk);
        v1 = bus0.read_data;
        @(posedge clk);
        #1;
        idle(9);
        drive(0, 1'b1, 1'b0, A_SYS, 32'h0);
        @(negedge clk);
        v2 = bus0.read_data;
        @(posedge clk);
        #1;
        checkOutput("sys_c10", v1, 32'd10);
        checkOutput("sys_delta", v2 - v1, 32'd10);
        applyStimulus(0, 1'b0, 1'b1, A_SYS, 32'h1234_5678);
        readExpect(0, A_SYS, 32'd22, "sys_ro");
`else
        v1 = 32'h0;
        v2 = 32'h0;
        idle(3);
        applyStimulus(0, 1'b0, 1'b1, A_SYS, 32'h1234_5678);
        readExpect(0, A_SYS, v1 | v2, "sys_off");
`endif

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
